// File: rtl/qpsk_mapper.sv
// Byte-to-QPSK Gray mapper: each accepted byte yields four {Q,I} symbols, MSB pair first.
// Optional symbol counter port sym_count enabled by QPSK_MAPPER_SYMCNT_EN.
module qpsk_mapper #(
  parameter int N   = 16,
  parameter int AMP = 23170
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     din,
  input  logic           din_valid,
  input  logic           din_last,
  output logic           in_ready,
  output logic [2*N-1:0] dout,
  output logic           dout_valid,
  output logic           dout_last,
  input  logic           out_ready
`ifdef QPSK_MAPPER_SYMCNT_EN
  ,
  output logic [31:0]    sym_count
`endif
);

  localparam logic [N-1:0] POS = N'(AMP);
  localparam logic [N-1:0] NEG = N'(-AMP);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [1:0] pair;
  logic       accept, consume;

  assign dout_valid = (state_q == SEND);
  assign consume    = dout_valid & out_ready;
  assign in_ready   = (state_q == EMPTY) | ((state_q == SEND) & (idx_q == 2'd3) & out_ready);
  assign accept     = din_valid & in_ready;

  // idx 0 selects [7:6], idx 3 selects [1:0]
  assign pair = 2'(byte_q >> {~idx_q, 1'b0});

  always_comb begin
    dout      = '0;
    dout_last = 1'b0;
    if (state_q == SEND) begin
      dout      = {(pair[0] ? NEG : POS), (pair[1] ? POS : NEG)};
      dout_last = last_q & (idx_q == 2'd3);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    last_d  = last_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = SEND;
        idx_d   = 2'd0;
        byte_d  = din;
        last_d  = din_last;
      end
      SEND: if (consume) begin
        if (idx_q == 2'd3) begin
          if (accept) begin
            idx_d  = 2'd0;
            byte_d = din;
            last_d = din_last;
          end else begin
            state_d = EMPTY;
            idx_d   = 2'd0;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      idx_q   <= 2'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

`ifdef QPSK_MAPPER_SYMCNT_EN
  logic [31:0] sym_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sym_cnt_q <= 32'd0;
    else if (consume) sym_cnt_q <= sym_cnt_q + 32'd1;
  end

  assign sym_count = sym_cnt_q;
`endif

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper with default N=16, AMP=23170.
module tb_qpsk_mapper;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid, din_last, in_ready;
  logic [31:0] dout;
  logic        dout_valid, dout_last, out_ready;
`ifdef QPSK_MAPPER_SYMCNT_EN
  logic [31:0] sym_count;
`endif

  int checks = 0;
  int errors = 0;

  qpsk_mapper dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .out_ready(out_ready)
`ifdef QPSK_MAPPER_SYMCNT_EN
    , .sym_count(sym_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sym(input string tag, input logic [31:0] d, input logic l, input logic ir);
    chk({tag, ".dout"}, 64'(dout), 64'(d));
    chk({tag, ".valid"}, 64'(dout_valid), 64'd1);
    chk({tag, ".last"}, 64'(dout_last), 64'(l));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".dout"}, 64'(dout), 64'd0);
    chk({tag, ".valid"}, 64'(dout_valid), 64'd0);
    chk({tag, ".last"}, 64'(dout_last), 64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  logic [31:0] e30 [4];
  logic [31:0] e31 [4];

  initial begin
    e30 = '{32'h5A82A57E, 32'hA57EA57E, 32'h5A825A82, 32'hA57E5A82};
    e31 = '{32'hA57E5A82, 32'h5A825A82, 32'hA57EA57E, 32'h5A82A57E};
    rst = 1'b1; din = 8'h00; din_valid = 1'b0; din_last = 1'b0; out_ready = 1'b1;
    #1 chk_idle("reset");
    tick; rst = 1'b0;

    // 0xB4 -> pairs 10,11,01,00
    din = 8'hB4; din_valid = 1'b1; din_last = 1'b0; out_ready = 1'b1;
    tick; din_valid = 1'b0;
    #1 chk_sym("b4_0", 32'h5A825A82, 1'b0, 1'b0); tick;
    #1 chk_sym("b4_1", 32'hA57E5A82, 1'b0, 1'b0); tick;
    #1 chk_sym("b4_2", 32'hA57EA57E, 1'b0, 1'b0); tick;
    #1 chk_sym("b4_3", 32'h5A82A57E, 1'b0, 1'b1); tick;
    #1 chk_idle("b4_done");

    // 0x00 then 0xFF(last) back-to-back
    din = 8'h00; din_valid = 1'b1; din_last = 1'b0;
    tick; din = 8'hFF; din_last = 1'b1;
    #1 chk_sym("b2b_0", 32'h5A82A57E, 1'b0, 1'b0); tick;
    #1 chk_sym("b2b_1", 32'h5A82A57E, 1'b0, 1'b0); tick;
    #1 chk_sym("b2b_2", 32'h5A82A57E, 1'b0, 1'b0); tick;
    #1 chk_sym("b2b_3", 32'h5A82A57E, 1'b0, 1'b1); tick;
    din_valid = 1'b0; din_last = 1'b0;
    #1 chk_sym("b2b_4", 32'hA57E5A82, 1'b0, 1'b0); tick;
    #1 chk_sym("b2b_5", 32'hA57E5A82, 1'b0, 1'b0); tick;
    #1 chk_sym("b2b_6", 32'hA57E5A82, 1'b0, 1'b0); tick;
    #1 chk_sym("b2b_7", 32'hA57E5A82, 1'b1, 1'b1); tick;
    #1 chk_idle("b2b_done");

    // 0x1B with stalls; junk on din while not accepted
    din = 8'h1B; din_valid = 1'b1; din_last = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0; din_valid = (k < 3); din = 8'h55; din_last = 1'b1;
      #1 chk_sym($sformatf("stall%0d_a", k), e30[k], 1'b0, 1'b0); tick;
      #1 chk_sym($sformatf("stall%0d_b", k), e30[k], 1'b0, 1'b0); tick;
      out_ready = 1'b1; din_valid = 1'b0; din_last = 1'b0;
      #1 chk_sym($sformatf("stall%0d_c", k), e30[k], 1'b0, k == 3); tick;
    end
    #1 chk_idle("stall_done");

    // reset after 2nd symbol of 0xE4
    din = 8'hE4; din_valid = 1'b1; din_last = 1'b1;
    tick; din_valid = 1'b0; din_last = 1'b0;
    #1 chk_sym("rst_0", e31[0], 1'b0, 1'b0); tick;
    #1 chk_sym("rst_1", e31[1], 1'b0, 1'b0); tick;
    rst = 1'b1;
    #1 chk_idle("rst_async");
    tick; rst = 1'b0;
    din = 8'hE4; din_valid = 1'b1; din_last = 1'b0;
    tick; din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk_sym($sformatf("post_rst%0d", k), e31[k], 1'b0, k == 3); tick;
    end
    #1 chk_idle("post_rst_done");

`ifdef QPSK_MAPPER_SYMCNT_EN
    chk("cnt_after_1", 64'(sym_count), 64'd4);
    din = 8'h12; din_valid = 1'b1; din_last = 1'b0;
    tick; din = 8'h34;
    repeat (4) tick;
    din_valid = 1'b0;
    repeat (4) tick;
    #1 chk("cnt_after_3", 64'(sym_count), 64'd12);
    force dut.sym_cnt_q = 32'hFFFFFFFE;
    #1 release dut.sym_cnt_q;
    din = 8'h00; din_valid = 1'b1;
    tick; din_valid = 1'b0;
    repeat (4) tick;
    #1 chk("cnt_wrap", 64'(sym_count), 64'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/qpsk_mapper.md
QPSK_MAPPER -- requirements
Module: qpsk_mapper

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the signed width of each I and Q component.
REQ-002 The block SHALL have parameter AMP, default 23170 (0.7071 in Q1.15), giving the constellation amplitude; legal range 1 to 2^(N-1)-1.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port din  input  8  data byte in.
REQ-006 The block SHALL have port din_valid  input  1  din/din_last qualified.
REQ-007 The block SHALL have port din_last  input  1  byte is the last of a packet.
REQ-008 The block SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-009 The block SHALL have port dout  output  2N  symbol {Q[N-1:0], I[N-1:0]}, two's complement.
REQ-010 The block SHALL have port dout_valid  output  1  dout/dout_last qualified.
REQ-011 The block SHALL have port dout_last  output  1  final symbol of the packet.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts the symbol.

Function
REQ-013 A byte SHALL be accepted only on a cycle with din_valid=1 and in_ready=1; a symbol SHALL be consumed only on a cycle with dout_valid=1 and out_ready=1.
REQ-014 Each accepted byte SHALL produce four symbols, bit pairs din[7:6], [5:4], [3:2], [1:0] in that order.
REQ-015 Gray mapping, pair b1b0: I = +AMP if b1=1, else -AMP; Q = -AMP if b0=1, else +AMP (10 -> +1+j, 00 -> -1+j, 11 -> +1-j, 01 -> -1-j).
REQ-016 The FSM SHALL have two states: EMPTY (no byte held) and SEND (byte held, 2-bit symbol index 0..3).
REQ-017 EMPTY transitions to SEND on byte accept, index 0; dout_valid SHALL rise the cycle after accept (latency 1).
REQ-018 In SEND, each consume SHALL advance the index; a consume at index 3 SHALL return the FSM to EMPTY, or reload SEND at index 0 if a byte is accepted the same cycle.
REQ-019 in_ready SHALL equal (state==EMPTY) OR (state==SEND AND index==3 AND out_ready), combinationally.
REQ-020 With out_ready held high and din_valid held high, the block SHALL sustain one symbol per cycle with no bubbles.
REQ-021 While dout_valid=1 and out_ready=0, dout, dout_valid and dout_last SHALL hold stable.
REQ-022 dout_last SHALL be 1 only on the index-3 symbol of a byte accepted with din_last=1; it SHALL be 0 on all other symbols.
REQ-023 din and din_last SHALL be ignored when the byte is not accepted.

Reset
REQ-024 On rst=1: state EMPTY, index 0, dout=0, dout_valid=0, dout_last=0, in_ready=1; this SHALL take effect immediately, without a clock edge.
REQ-025 Reset mid-byte SHALL discard the remaining symbols; the first byte accepted after reset release SHALL map from pair [7:6].

Configuration
REQ-026 When macro QPSK_MAPPER_SYMCNT_EN is defined, the block SHALL add port sym_count  output  32, reset 0, incremented by 1 on every symbol consume and wrapping 0xFFFFFFFF -> 0.
REQ-027 When QPSK_MAPPER_SYMCNT_EN is undefined, the sym_count port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-028 Byte 0xB4 accepted, out_ready=1 -> dout = 0x5A825A82, 0xA57E5A82, 0xA57EA57E, 0x5A82A57E on four consecutive cycles, dout_last=0 on all four.
REQ-029 Bytes 0x00 and 0xFF (last) sent back-to-back, out_ready=1 -> 8 symbols with no gap: 4 x 0x5A82A57E, then 4 x 0xA57E5A82; dout_last=1 only on the 8th.
REQ-030 Byte 0x1B, out_ready toggled 1,0,0,1,... -> dout holds during stalls; in_ready=0 until the index-3 consume; symbol order is 00,01,10,11.
REQ-031 rst pulsed after the 2nd symbol of 0xE4 -> outputs clear at once; next byte 0xE4 -> 4 full symbols beginning with pair 11.
REQ-032 With QPSK_MAPPER_SYMCNT_EN defined, 3 bytes streamed -> sym_count = 12; with the counter preloaded near 0xFFFFFFFF, the count wraps to 0.
